cdr_acq_ctrl: RTL and testbench

- Acquisition/tracking sequencer for the baud-rate PAM4 CDR loop.
- Monitors the MM phase-detector output (phi) at symbol strobes and sequences the loop through clear, acquire (wide gains), lock-check and locked (narrow gains).
- Drives loop-filter shift gains and integrator clear, and declares lock or loss-of-lock.
- Sits beside the PI filter and DCO; consumes their sample strobe and phi.

---
 rtl/cdr_ctrl_pkg.sv | 29 ++
 rtl/cdr_err_window.sv | 62 ++++++
 rtl/cdr_acq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cdr_acq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdr_ctrl_pkg.sv
// Shared types and defaults for the CDR acquisition sequencer.
// State encoding, gain widths and metric sizing live here.
package cdr_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_ACQ    = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_LOCKED = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    CLEAR  = ST_CLEAR,
    ACQ    = ST_ACQ,
    CHECK  = ST_CHECK,
    LOCKED = ST_LOCKED
  } state_t;

  localparam int GAIN_W     = 5;
  localparam int KP_ACQ_DEF = 10;
  localparam int KI_ACQ_DEF = 16;
  localparam int KP_TRK_DEF = 12;
  localparam int KI_TRK_DEF = 18;

  function automatic int metric_w(input int win_log2);
    return 16 + win_log2;
  endfunction

endpackage

// File: rtl/cdr_err_window.sv
// Windowed |phi| accumulator for the CDR lock detector.
// Emits a one-cycle win_done together with the new metric.
module cdr_err_window
  import cdr_ctrl_pkg::*;
#(
  parameter int WIN_LOG2 = 8,
  localparam int MW = metric_w(WIN_LOG2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               sample_en,
  input  logic signed [15:0] phi,
  output logic               win_done,
  output logic [MW-1:0]      metric
);

  logic [14:0]         mag;
  logic [MW:0]         sum;
  logic [MW-1:0]       acc;
  logic [MW-1:0]       acc_n;
  logic [WIN_LOG2-1:0] cnt;

  // -32768 has no positive twin; clamp it to 32767
  always_comb begin
    mag = phi[14:0];
    if (phi[15]) begin
      if (phi[14:0] == 15'd0)
        mag = 15'h7fff;
      else
        mag = ~phi[14:0] + 15'd1;
    end
    sum   = {1'b0, acc} + (MW+1)'(mag);
    acc_n = sum[MW] ? '1 : sum[MW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      win_done <= 1'b0;
      metric   <= '0;
    end else begin
      win_done <= 1'b0;
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (sample_en) begin
        if (&cnt) begin
          metric   <= acc_n;
          acc      <= '0;
          cnt      <= '0;
          win_done <= 1'b1;
        end else begin
          acc <= acc_n;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdr_acq_ctrl.sv
// Acquisition/tracking sequencer for the baud-rate PAM4 CDR loop.
// Sequences clear, acquire, lock-check and locked with gain switching.
module cdr_acq_ctrl
  import cdr_ctrl_pkg::*;
#(
  parameter int WIN_LOG2       = 8,
  parameter int ACQ_SYMS       = 1024,
  parameter int CLR_CYC        = 16,
  parameter int KP_ACQ         = KP_ACQ_DEF,
  parameter int KI_ACQ         = KI_ACQ_DEF,
  parameter int KP_TRK         = KP_TRK_DEF,
  parameter int KI_TRK         = KI_TRK_DEF,
  parameter int LOCK_THR       = 16384,
  parameter int UNLOCK_THR     = 32768,
  parameter int LOCK_WINS      = 4,
  parameter int UNLOCK_WINS    = 2,
  parameter int CHECK_MAX_WINS = 64,
  localparam int MW = metric_w(WIN_LOG2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               restart,
  input  logic               sample_en,
  input  logic signed [15:0] phi,
  output logic [GAIN_W-1:0]  kp_shift,
  output logic [GAIN_W-1:0]  ki_shift,
  output logic               loop_clr,
  output logic               locked,
  output logic               lol,
  output logic [2:0]         state,
  output logic [3:0]         retry_cnt,
  output logic [MW-1:0]      win_metric
);

  localparam logic [15:0] CLR_LAST = 16'(CLR_CYC - 1);
  localparam logic [15:0] ACQ_LAST = 16'(ACQ_SYMS - 1);
  localparam logic [15:0] CHK_LAST = 16'(CHECK_MAX_WINS - 1);
  localparam logic [7:0]  LOCK_N   = 8'(LOCK_WINS);
  localparam logic [7:0]  UNLK_N   = 8'(UNLOCK_WINS);
  localparam logic [MW-1:0] LOCK_T = MW'(LOCK_THR);
  localparam logic [MW-1:0] UNLK_T = MW'(UNLOCK_THR);
  localparam logic [GAIN_W-1:0] KPA = GAIN_W'(KP_ACQ);
  localparam logic [GAIN_W-1:0] KIA = GAIN_W'(KI_ACQ);
  localparam logic [GAIN_W-1:0] KPT = GAIN_W'(KP_TRK);
  localparam logic [GAIN_W-1:0] KIT = GAIN_W'(KI_TRK);

  state_t      st, st_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0]  run, run_n, hit;
  logic [3:0]  retry_n;
  logic        lol_n, force_entry, entry;
  logic        win_clr, win_done, trk;

  cdr_err_window #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_win (
    .clk       (clk),
    .rst       (rst),
    .clr       (win_clr),
    .sample_en (sample_en),
    .phi       (phi),
    .win_done  (win_done),
    .metric    (win_metric)
  );

  // cnt is the per-state timer: clear cycles, acq symbols or check windows
  always_comb begin
    st_n        = st;
    cnt_n       = cnt;
    run_n       = run;
    hit         = 8'd0;
    retry_n     = retry_cnt;
    lol_n       = 1'b0;
    force_entry = 1'b0;
    if (!en) begin
      st_n        = IDLE;
      force_entry = 1'b1;
    end else if (restart && st != IDLE) begin
      st_n        = CLEAR;
      force_entry = 1'b1;
    end else begin
      unique case (st)
        IDLE: st_n = CLEAR;
        CLEAR: begin
          if (cnt == CLR_LAST) st_n = ACQ;
          else cnt_n = cnt + 16'd1;
        end
        ACQ: begin
          if (sample_en) begin
            if (cnt == ACQ_LAST) st_n = ACQ_NEXT();
            else cnt_n = cnt + 16'd1;
          end
        end
        CHECK: begin
          if (win_done) begin
            hit   = (win_metric <= LOCK_T) ? run + 8'd1 : 8'd0;
            run_n = hit;
            if (hit == LOCK_N) begin
              st_n = LOCKED;
            end else if (cnt == CHK_LAST) begin
              st_n = CLEAR;
              if (retry_cnt != 4'hf) retry_n = retry_cnt + 4'd1;
            end else begin
              cnt_n = cnt + 16'd1;
            end
          end
        end
        LOCKED: begin
          if (win_done) begin
            hit   = (win_metric > UNLK_T) ? run + 8'd1 : 8'd0;
            run_n = hit;
            if (hit == UNLK_N) begin
              st_n  = CLEAR;
              lol_n = 1'b1;
            end
          end
        end
        default: st_n = IDLE;
      endcase
    end
    entry = force_entry || (st_n != st);
    if (entry) begin
      cnt_n = 16'd0;
      run_n = 8'd0;
    end
    win_clr = entry || st_n == IDLE || st_n == CLEAR;
    trk     = st_n == CHECK || st_n == LOCKED;
  end

  function automatic state_t ACQ_NEXT();
    return CHECK;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      cnt       <= 16'd0;
      run       <= 8'd0;
      retry_cnt <= 4'd0;
      kp_shift  <= KPA;
      ki_shift  <= KIA;
      loop_clr  <= 1'b1;
      locked    <= 1'b0;
      lol       <= 1'b0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      run       <= run_n;
      retry_cnt <= retry_n;
      kp_shift  <= trk ? KPT : KPA;
      ki_shift  <= trk ? KIT : KIA;
      loop_clr  <= st_n == IDLE || st_n == CLEAR;
      locked    <= st_n == LOCKED;
      lol       <= lol_n;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_cdr_acq_ctrl.sv
// Randomized bench for cdr_acq_ctrl against a behavioural model.
// Directed phases cover lock, unlock, retry, saturation and reset.
module tb_cdr_acq_ctrl;

  localparam int WL   = 2;
  localparam int NACQ = 8;
  localparam int NCLR = 4;
  localparam int LTHR = 500;
  localparam int UTHR = 1000;
  localparam int LWIN = 2;
  localparam int UWIN = 2;
  localparam int CMAX = 3;
  localparam int MW   = 16 + WL;
  localparam longint MMAX = (longint'(1) << MW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              restart = 1'b0;
  logic              sample_en = 1'b0;
  logic signed [15:0] phi = '0;
  logic [4:0]        kp_shift, ki_shift;
  logic              loop_clr, locked, lol;
  logic [2:0]        state;
  logic [3:0]        retry_cnt;
  logic [MW-1:0]     win_metric;

  int checks = 0;
  int errors = 0;

  cdr_acq_ctrl #(
    .WIN_LOG2       (WL),
    .ACQ_SYMS       (NACQ),
    .CLR_CYC        (NCLR),
    .LOCK_THR       (LTHR),
    .UNLOCK_THR     (UTHR),
    .LOCK_WINS      (LWIN),
    .UNLOCK_WINS    (UWIN),
    .CHECK_MAX_WINS (CMAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .restart    (restart),
    .sample_en  (sample_en),
    .phi        (phi),
    .kp_shift   (kp_shift),
    .ki_shift   (ki_shift),
    .loop_clr   (loop_clr),
    .locked     (locked),
    .lol        (lol),
    .state      (state),
    .retry_cnt  (retry_cnt),
    .win_metric (win_metric)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: phases 0 idle,1 clear,2 acq,3 check,4 locked
  int     m_st = 0, m_cyc = 0, m_syms = 0, m_wins = 0;
  int     m_good = 0, m_bad = 0, m_retry = 0;
  int     m_lol = 0, m_pend = 0;
  longint m_metric = 0;
  int     m_q[$];

  task automatic model_step();
    int nxt, lol_n, entry, pend_n, mag;
    longint s;
    if (rst) begin
      m_st = 0; m_cyc = 0; m_syms = 0; m_wins = 0;
      m_good = 0; m_bad = 0; m_retry = 0; m_lol = 0;
      m_pend = 0; m_metric = 0; m_q.delete();
      return;
    end
    nxt = m_st; lol_n = 0; entry = 0;
    if (!en) begin
      nxt = 0; entry = 1;
    end else if (restart && m_st != 0) begin
      nxt = 1; entry = 1;
    end else if (m_st == 0) begin
      nxt = 1;
    end else if (m_st == 1) begin
      m_cyc++;
      if (m_cyc == NCLR) nxt = 2;
    end else if (m_st == 2) begin
      if (sample_en) begin
        m_syms++;
        if (m_syms == NACQ) nxt = 3;
      end
    end else if (m_st == 3) begin
      if (m_pend != 0) begin
        m_good = (m_metric <= LTHR) ? m_good + 1 : 0;
        m_wins++;
        if (m_good == LWIN) nxt = 4;
        else if (m_wins == CMAX) begin
          nxt = 1;
          m_retry = (m_retry < 15) ? m_retry + 1 : 15;
        end
      end
    end else begin
      if (m_pend != 0) begin
        m_bad = (m_metric > UTHR) ? m_bad + 1 : 0;
        if (m_bad == UWIN) begin
          nxt = 1; lol_n = 1;
        end
      end
    end
    if (nxt != m_st) entry = 1;
    if (entry) begin
      m_cyc = 0; m_syms = 0; m_wins = 0; m_good = 0; m_bad = 0;
    end
    pend_n = 0;
    if (entry || nxt <= 1) begin
      m_q.delete();
    end else if (sample_en) begin
      mag = int'(phi);
      if (mag < 0) mag = -mag;
      if (mag > 32767) mag = 32767;
      m_q.push_back(mag);
      if (m_q.size() == (1 << WL)) begin
        s = 0;
        foreach (m_q[i]) s += m_q[i];
        m_metric = (s > MMAX) ? MMAX : s;
        m_q.delete();
        pend_n = 1;
      end
    end
    m_pend = pend_n;
    m_st = nxt;
    m_lol = lol_n;
  endtask

  task automatic compare_all();
    int trk;
    trk = (m_st >= 3) ? 1 : 0;
    chk("state", int'(state), m_st);
    chk("kp", int'(kp_shift), trk ? 12 : 10);
    chk("ki", int'(ki_shift), trk ? 18 : 16);
    chk("loop_clr", int'(loop_clr), (m_st <= 1) ? 1 : 0);
    chk("locked", int'(locked), (m_st == 4) ? 1 : 0);
    chk("lol", int'(lol), m_lol);
    chk("retry", int'(retry_cnt), m_retry);
    chk("metric", int'(win_metric), int'(m_metric));
  endtask

  // pat: 0 zero, 1 +768, 2 alternating 768, 3 -32768, 4 random
  int pat = 0;
  int rnd = 0;
  int quiet = 1;
  bit flip = 1'b0;

  task automatic tick();
    int v;
    if (rnd != 0) sample_en = 1'($urandom_range(0, 1));
    else sample_en = !sample_en;
    case (pat)
      0: phi = 16'sd0;
      1: phi = 16'sd768;
      2: begin
        phi = flip ? 16'sd768 : -16'sd768;
        if (sample_en) flip = !flip;
      end
      3: phi = -16'sd32768;
      default: begin
        if (quiet != 0) begin
          v = int'($urandom_range(0, 200)) - 100;
          phi = 16'(v);
        end else if ($urandom_range(0, 7) == 0) begin
          phi = -16'sd32768;
        end else begin
          phi = 16'($urandom);
        end
      end
    endcase
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wait_st(input int target, input int budget);
    int n = 0;
    while (int'(state) != target && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("reach_%0d", target), int'(state), target);
  endtask

  initial begin
    int acq_strobes;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_state", int'(state), 0);
    chk("rst_loop_clr", int'(loop_clr), 1);

    en = 1'b1;
    pat = 0;
    wait_st(4, 200);
    chk("lock_kp", int'(kp_shift), 12);
    chk("lock_flag", int'(locked), 1);

    pat = 1;
    wait_st(1, 200);
    chk("unlock_locked", int'(locked), 0);

    pat = 2;
    wait_st(3, 200);
    wait_st(1, 200);
    chk("retry_one", int'(retry_cnt), 1);
    repeat (19) begin
      wait_st(3, 200);
      wait_st(1, 200);
    end
    chk("retry_sat", int'(retry_cnt), 15);

    pat = 3;
    repeat (40) tick();
    chk("metric_sat", int'(win_metric), 131068);

    pat = 0;
    wait_st(4, 300);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_state", int'(state), 1);
    chk("rs_locked", int'(locked), 0);
    chk("rs_lol", int'(lol), 0);
    wait_st(2, 100);
    en = 1'b0;
    tick();
    chk("enlow_state", int'(state), 0);
    chk("enlow_clr", int'(loop_clr), 1);
    en = 1'b1;

    wait_st(3, 200);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_state", int'(state), 0);
    chk("mid_kp", int'(kp_shift), 10);
    chk("mid_ki", int'(ki_shift), 16);
    chk("mid_clr", int'(loop_clr), 1);
    chk("mid_locked", int'(locked), 0);
    chk("mid_retry", int'(retry_cnt), 0);
    chk("mid_metric", int'(win_metric), 0);
    acq_strobes = 0;
    for (int n = 0; n < 300 && int'(state) != 4; n++) begin
      if (int'(state) == 2 && sample_en == 1'b0) acq_strobes++;
      tick();
    end
    chk("relock_state", int'(state), 4);
    chk("relock_syms", acq_strobes, NACQ);

    rnd = 1;
    pat = 4;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) quiet = ($urandom_range(0, 3) != 0) ? 1 : 0;
      rst = ($urandom_range(0, 999) == 0);
      restart = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst = 1'b0;
    restart = 1'b0;
    en = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
